// File: rtl/fc_ctrl.sv
// Frame sequencer around the fully connected layer: serial word load, launch pulse,
// result snapshot and a one-compare-per-cycle signed argmax.
module fc_ctrl #(
    parameter int data_width  = 16,
    parameter int numofinput  = 100,
    parameter int numofoutput = 10,
    parameter int idx_width   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [data_width-1:0]             in_data,
    output logic                              in_ready,
    output logic [numofinput*data_width-1:0]  i_fc,
    output logic                              start_flag,
    input  logic                              over_flag,
    input  logic [numofoutput*data_width-1:0] f_fc,
    output logic [idx_width-1:0]              class_idx,
    output logic [data_width-1:0]             max_value,
    output logic                              class_valid,
    output logic [2:0]                        dbg_state
);

    localparam int CW = (numofinput > 1) ? $clog2(numofinput) : 1;
    localparam int JW = (numofoutput > 1) ? $clog2(numofoutput) : 1;

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Handshake: a word moves on a rising edge where in_valid && in_ready; in_ready is
    // high exactly in LOAD, and in_valid is ignored everywhere else.
    state_t                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [numofinput*data_width-1:0] i_fc_q, i_fc_d;
    logic [numofoutput*data_width-1:0] snap_q, snap_d;
    logic [data_width-1:0]            best_val_q, best_val_d;
    logic [idx_width-1:0]             best_idx_q, best_idx_d;
    logic [JW-1:0]                    j_q, j_d;
    logic                             start_q, start_d;
    logic                             valid_q, valid_d;
    logic [idx_width-1:0]             cidx_q, cidx_d;
    logic [data_width-1:0]            cmax_q, cmax_d;
    logic [data_width-1:0]            cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            i_fc_q     <= '0;
            snap_q     <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            j_q        <= '0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            cidx_q     <= '0;
            cmax_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_fc_q     <= i_fc_d;
            snap_q     <= snap_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            j_q        <= j_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            cidx_q     <= cidx_d;
            cmax_q     <= cmax_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_fc_d     = i_fc_q;
        snap_d     = snap_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        j_d        = j_q;
        cand       = snap_q[j_q*data_width +: data_width];

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    i_fc_d[cnt_q*data_width +: data_width] = in_data;
                    if (cnt_q == CW'(numofinput - 1)) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (over_flag) begin
                    snap_d     = f_fc;
                    best_val_d = f_fc[data_width-1:0];
                    best_idx_d = '0;
                    j_d        = JW'(1);
                    state_d    = (numofoutput == 1) ? S_DONE : S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                // Strictly greater only, so equal scores keep the earlier index.
                if ($signed(cand) > $signed(best_val_q)) begin
                    best_val_d = cand;
                    best_idx_d = idx_width'(j_q);
                end
                j_d = j_q + JW'(1);
                if (j_q == JW'(numofoutput - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase

        // Outputs are registered against the state being entered so they line up with it.
        start_d = (state_d == S_START);
        valid_d = (state_d == S_DONE);
        cidx_d  = valid_d ? best_idx_d : cidx_q;
        cmax_d  = valid_d ? best_val_d : cmax_q;
    end

    assign in_ready    = (state_q == S_LOAD);
    assign i_fc        = i_fc_q;
    assign start_flag  = start_q;
    assign class_valid = valid_q;
    assign class_idx   = cidx_q;
    assign max_value   = cmax_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: random frames checked against a word-array / argmax model,
// plus reset, tie, snapshot and back-to-back scenarios.
module tb_fc_ctrl;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [NI*DW-1:0]  i_fc;
    logic              start_flag;
    logic              over_flag;
    logic [NO*DW-1:0]  f_fc;
    logic [IW-1:0]     class_idx;
    logic [DW-1:0]     max_value;
    logic              class_valid;
    logic [2:0]        dbg_state;

    fc_ctrl #(
        .data_width(DW), .numofinput(NI), .numofoutput(NO), .idx_width(IW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .i_fc(i_fc), .start_flag(start_flag),
        .over_flag(over_flag), .f_fc(f_fc), .class_idx(class_idx),
        .max_value(max_value), .class_valid(class_valid), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    model_words [NI];
    logic [DW-1:0]    frame_words [NI];
    logic [DW-1:0]    fv [NO];
    logic [IW-1:0]    model_idx;
    logic [DW-1:0]    model_max;
    logic [IW+DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [NI*DW-1:0] pack_words();
        logic [NI*DW-1:0] v = '0;
        for (int k = 0; k < NI; k++) v[k*DW +: DW] = model_words[k];
        return v;
    endfunction

    function automatic logic [NO*DW-1:0] pack_fv();
        logic [NO*DW-1:0] v = '0;
        for (int k = 0; k < NO; k++) v[k*DW +: DW] = fv[k];
        return v;
    endfunction

    // First index holding the largest signed value.
    function automatic int ref_argmax();
        int best = 0;
        for (int k = 1; k < NO; k++)
            if ($signed(fv[k]) > $signed(fv[best])) best = k;
        return best;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NI; k++) model_words[k] = '0;
        model_idx = '0;
        model_max = '0;
        exp_q.delete();
    endtask

    task automatic check_held();
        check("class_idx_hold", 64'(class_idx), 64'(model_idx));
        check("max_value_hold", 64'(max_value), 64'(model_max));
    endtask

    task automatic check_reset_vals();
        check("rst_i_fc", 64'(i_fc), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_start", 64'(start_flag), 64'(0));
        check("rst_class_valid", 64'(class_valid), 64'(0));
        check("rst_class_idx", 64'(class_idx), 64'(0));
        check("rst_max_value", 64'(max_value), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
    endtask

    // Starts and ends on a falling edge; a full load ends in the START cycle.
    task automatic load_frame(input int nwords, input int gap, input bit hold_over);
        int g;
        if (hold_over) begin
            over_flag = 1'b1;
            f_fc = (NO*DW)'({$urandom(), $urandom()});
        end
        for (int k = 0; k < nwords; k++) begin
            g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < g; i++) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom());
                check("ready_gap", 64'(in_ready), 64'(1));
                @(negedge clk);
                check("no_take_gap", 64'(i_fc), 64'(pack_words()));
            end
            in_valid = 1'b1;
            in_data  = frame_words[k];
            check("ready_load", 64'(in_ready), 64'(1));
            check("start_idle", 64'(start_flag), 64'(0));
            check_held();
            @(negedge clk);
            model_words[k] = frame_words[k];
            in_valid = 1'b0;
            check("i_fc_word", 64'(i_fc), 64'(pack_words()));
        end
        if (nwords == NI) begin
            check("start_flag", 64'(start_flag), 64'(1));
            check("ready_start", 64'(in_ready), 64'(0));
        end
    endtask

    // Entered in the START cycle; returns in the LOAD cycle after DONE.
    task automatic run_fc(input bit early, input bit perturb);
        int best;
        int lat;
        logic [IW+DW-1:0] e;
        @(negedge clk);
        check("start_len", 64'(start_flag), 64'(0));
        check("ready_wait", 64'(in_ready), 64'(0));
        if (!early) begin
            over_flag = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                check("valid_wait", 64'(class_valid), 64'(0));
                @(negedge clk);
                check("i_fc_stable", 64'(i_fc), 64'(pack_words()));
            end
            over_flag = 1'b1;
        end
        f_fc = pack_fv();
        best = ref_argmax();
        exp_q.push_back({IW'(best), fv[best]});
        @(negedge clk);
        over_flag = 1'b0;
        if (perturb) f_fc = {NO{16'h7FFF}};
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (class_valid) begin
                lat = c;
                break;
            end
            check("ready_busy", 64'(in_ready), 64'(0));
            check_held();
        end
        check("latency", 64'(lat), 64'(NO));
        if (lat != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_idx = e[IW+DW-1:DW];
            model_max = e[DW-1:0];
        end
        check("class_idx", 64'(class_idx), 64'(model_idx));
        check("max_value", 64'(max_value), 64'(model_max));
        check("i_fc_done", 64'(i_fc), 64'(pack_words()));
        @(negedge clk);
        check("valid_len", 64'(class_valid), 64'(0));
        check("ready_after", 64'(in_ready), 64'(1));
        check_held();
    endtask

    task automatic rand_fv();
        for (int k = 0; k < NO; k++) begin
            case ($urandom_range(0, 3))
                0:       fv[k] = 16'h8000;
                1:       fv[k] = 16'h7FFF;
                2:       fv[k] = DW'($urandom_range(0, 2));
                default: fv[k] = DW'($urandom());
            endcase
        end
    endtask

    task automatic rand_words();
        for (int k = 0; k < NI; k++) frame_words[k] = DW'($urandom());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        over_flag = 1'b0;
        f_fc = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // Reset two words into a load: partial frame is discarded.
        for (int k = 0; k < NI; k++) frame_words[k] = DW'(k + 1);
        load_frame(2, 0, 0);
        rst = 1'b1;
        #1;
        clear_model();
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        // Gapped load of 1..4, then a plain argmax.
        load_frame(NI, 1, 0);
        check("i_fc_const", 64'(i_fc), 64'h0004_0003_0002_0001);
        fv[0] = 16'h0002; fv[1] = 16'hFFF0; fv[2] = 16'h0005;
        run_fc(0, 0);
        check("idx_const", 64'(class_idx), 64'(2));
        check("max_const", 64'(max_value), 64'h0005);

        // Tie at the top with the most negative value present.
        rand_words();
        load_frame(NI, 0, 0);
        fv[0] = 16'h7FFF; fv[1] = 16'h7FFF; fv[2] = 16'h8000;
        run_fc(0, 0);
        check("tie_idx", 64'(class_idx), 64'(0));

        // Inputs change right after the snapshot.
        rand_words();
        load_frame(NI, 2, 0);
        fv[0] = 16'h0001; fv[1] = 16'h0002; fv[2] = 16'h0003;
        run_fc(0, 1);

        // Back-to-back with over_flag already high during LOAD and START.
        rand_words();
        load_frame(NI, 0, 1);
        rand_fv();
        run_fc(1, 0);

        // Reset while waiting with over_flag pending.
        rand_words();
        load_frame(NI, 0, 0);
        @(negedge clk);
        over_flag = 1'b1;
        f_fc = (NO*DW)'({$urandom(), $urandom()});
        rst = 1'b1;
        #1;
        clear_model();
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        over_flag = 1'b0;
        @(negedge clk);
        check("no_valid_after_rst", 64'(class_valid), 64'(0));
        check("no_start_after_rst", 64'(start_flag), 64'(0));
        check("ready_after_rst", 64'(in_ready), 64'(1));

        for (int f = 0; f < 14; f++) begin
            bit early;
            early = 1'($urandom_range(0, 1));
            rand_words();
            load_frame(NI, int'($urandom_range(0, 2)), early);
            rand_fv();
            run_fc(early, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
